mor1kx_store_buffer_fwd: RTL and testbench

//  Parametrised register-based store FIFO between LSU and data bus.

---
 rtl/mor1kx_sb_pkg.sv | 23 ++
 rtl/mor1kx_sb_byte_fwd.sv | 25 ++
 rtl/mor1kx_store_buffer_fwd.sv | 122 ++++++++++++
 tb/tb_mor1kx_store_buffer_fwd.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mor1kx_sb_pkg.sv
// mor1kx_sb_pkg: store buffer entry layout {pc, adr, dat, bsel, atomic} (atomic at bit 0) and word-address compare helper
package mor1kx_sb_pkg;
  localparam int SB_ATOMIC_LSB = 0;
  localparam int SB_BSEL_LSB = 1;
  function automatic int sb_entry_width(input int w);
    return 3 * w + w / 8 + 1;
  endfunction
  function automatic int sb_dat_lsb(input int w);
    return 1 + w / 8;
  endfunction
  function automatic int sb_adr_lsb(input int w);
    return 1 + w / 8 + w;
  endfunction
  function automatic int sb_pc_lsb(input int w);
    return 1 + w / 8 + 2 * w;
  endfunction
  function automatic logic sb_word_eq(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    m[1:0] = 2'b00;
    return ((a ^ b) & m) == '0;
  endfunction
endpackage

// File: rtl/mor1kx_sb_byte_fwd.sv
// mor1kx_sb_byte_fwd: one byte lane of forwarding; hit/lane/age per entry in, youngest hitting byte and covered flag out
module mor1kx_sb_byte_fwd #(
  parameter int N = 8,
  parameter int AW = 3
) (
  input  logic [N-1:0]         hit,
  input  logic [N-1:0][7:0]    lane,
  input  logic [N-1:0][AW-1:0] age,
  output logic [7:0]           dat,
  output logic                 covered
);
  logic [AW-1:0] best;
  always_comb begin
    dat = '0;
    covered = 1'b0;
    best = '0;
    for (int i = 0; i < N; i++) begin
      if (hit[i] && (!covered || age[i] > best)) begin
        dat = lane[i];
        best = age[i];
        covered = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mor1kx_store_buffer_fwd.sv
// mor1kx_store_buffer_fwd: store FIFO with per-byte store-to-load forwarding; ports clk/rst, push (write_i + store fields), head (pc_o..atomic_o, read_i), full_o/empty_o/count_o, lookup_adr_i -> lookup_dat_o/bsel_o/hit_o; MOR1KX_SB_COMBINE_EN merges writes into the tail entry
module mor1kx_store_buffer_fwd
  import mor1kx_sb_pkg::*;
#(
  parameter int DEPTH_WIDTH = 3,
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   dat_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0] bsel_i,
  input  logic                              atomic_i,
  input  logic                              write_i,
  output logic                              full_o,
  output logic                              empty_o,
  output logic [DEPTH_WIDTH:0]              count_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   pc_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] bsel_o,
  output logic                              atomic_o,
  input  logic                              read_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   lookup_adr_i,
  output logic [OPTION_OPERAND_WIDTH-1:0]   lookup_dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] lookup_bsel_o,
  output logic                              lookup_hit_o
);
  localparam int W = OPTION_OPERAND_WIDTH;
  localparam int BW = W / 8;
  localparam int DEPTH = 2 ** DEPTH_WIDTH;
  localparam int EW = sb_entry_width(W);
  localparam int DAT_LSB = sb_dat_lsb(W);
  localparam int ADR_LSB = sb_adr_lsb(W);
  localparam int PC_LSB = sb_pc_lsb(W);
  logic [EW-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid, match;
  logic [DEPTH_WIDTH:0] wptr, rptr;
  logic [DEPTH_WIDTH-1:0] wa, ra;
  logic [DEPTH-1:0][DEPTH_WIDTH-1:0] age;
  logic [EW-1:0] head;
  logic push, pop, merge;
  assign wa = wptr[DEPTH_WIDTH-1:0];
  assign ra = rptr[DEPTH_WIDTH-1:0];
  assign empty_o = wptr == rptr;
  assign full_o = (wptr[DEPTH_WIDTH] != rptr[DEPTH_WIDTH]) && (wa == ra);
  assign count_o = wptr - rptr;
  assign pop = read_i && !empty_o;
  assign push = write_i && (!full_o || read_i) && !merge;
`ifdef MOR1KX_SB_COMBINE_EN
  logic [DEPTH_WIDTH-1:0] ta;
  logic [EW-1:0] tail, merged;
  logic [W-1:0] mdat;
  assign ta = wa - DEPTH_WIDTH'(1);
  assign tail = mem[ta];
  // A tail that is leaving this cycle cannot absorb the write, or the bytes would be lost
  assign merge = write_i && !empty_o && sb_word_eq(64'(tail[ADR_LSB +: W]), 64'(adr_i), W) &&
                 !atomic_i && !tail[SB_ATOMIC_LSB] && (count_o > (DEPTH_WIDTH+1)'(1) || !read_i);
  always_comb begin
    mdat = tail[DAT_LSB +: W];
    for (int i = 0; i < BW; i++) mdat[8*i +: 8] = bsel_i[i] ? dat_i[8*i +: 8] : mdat[8*i +: 8];
  end
  assign merged = {pc_i, tail[ADR_LSB +: W], mdat, tail[SB_BSEL_LSB +: BW] | bsel_i, 1'b0};
`else
  assign merge = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      valid <= '0;
    end else begin
      // Clear before set: when full, push and pop share the same slot
      if (pop) begin
        rptr <= rptr + (DEPTH_WIDTH+1)'(1);
        valid[ra] <= 1'b0;
      end
      if (push) begin
        wptr <= wptr + (DEPTH_WIDTH+1)'(1);
        valid[wa] <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wa] <= {pc_i, adr_i, dat_i, bsel_i, atomic_i};
`ifdef MOR1KX_SB_COMBINE_EN
    if (merge) mem[ta] <= merged;
`endif
  end
  assign head = mem[ra];
  assign pc_o = empty_o ? '0 : head[PC_LSB +: W];
  assign adr_o = empty_o ? '0 : head[ADR_LSB +: W];
  assign dat_o = empty_o ? '0 : head[DAT_LSB +: W];
  assign bsel_o = empty_o ? '0 : head[SB_BSEL_LSB +: BW];
  assign atomic_o = empty_o ? 1'b0 : head[SB_ATOMIC_LSB];
  // Age is distance from the head, so the youngest entry has the largest age regardless of wrap
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age[i] = DEPTH_WIDTH'(i) - ra;
      match[i] = valid[i] && sb_word_eq(64'(mem[i][ADR_LSB +: W]), 64'(lookup_adr_i), W);
    end
  end
  for (genvar b = 0; b < BW; b++) begin : g_lane
    logic [DEPTH-1:0] hit;
    logic [DEPTH-1:0][7:0] lane;
    always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
        hit[i] = match[i] && mem[i][SB_BSEL_LSB + b];
        lane[i] = mem[i][DAT_LSB + 8*b +: 8];
      end
    end
    mor1kx_sb_byte_fwd #(.N(DEPTH), .AW(DEPTH_WIDTH)) u_fwd (
      .hit(hit),
      .lane(lane),
      .age(age),
      .dat(lookup_dat_o[8*b +: 8]),
      .covered(lookup_bsel_o[b])
    );
  end
  assign lookup_hit_o = |lookup_bsel_o;
endmodule

// File: tb/tb_mor1kx_store_buffer_fwd.sv
// tb_mor1kx_store_buffer_fwd: directed scenarios plus random traffic checked against a queue-based reference model
module tb_mor1kx_store_buffer_fwd;
`ifdef MOR1KX_SB_COMBINE_EN
  localparam bit COMB = 1'b1;
`else
  localparam bit COMB = 1'b0;
`endif
  typedef struct {
    logic [31:0] pc, adr, dat;
    logic [3:0] bsel;
    logic atomic;
  } ent_t;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] pc_i = '0, adr_i = '0, dat_i = '0, lookup_adr_i = '0;
  logic [3:0] bsel_i = '0;
  logic atomic_i = 1'b0, write_i = 1'b0, read_i = 1'b0;
  logic full_o, empty_o, atomic_o, lookup_hit_o;
  logic [3:0] count_o, bsel_o, lookup_bsel_o;
  logic [31:0] pc_o, adr_o, dat_o, lookup_dat_o;
  ent_t q[$];
  int checks = 0, errors = 0;
  logic [31:0] bases [4] = '{32'h100, 32'h104, 32'h200, 32'h3fc};
  mor1kx_store_buffer_fwd dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .adr_i(adr_i), .dat_i(dat_i), .bsel_i(bsel_i),
    .atomic_i(atomic_i), .write_i(write_i), .full_o(full_o), .empty_o(empty_o),
    .count_o(count_o), .pc_o(pc_o), .adr_o(adr_o), .dat_o(dat_o), .bsel_o(bsel_o),
    .atomic_o(atomic_o), .read_i(read_i), .lookup_adr_i(lookup_adr_i),
    .lookup_dat_o(lookup_dat_o), .lookup_bsel_o(lookup_bsel_o), .lookup_hit_o(lookup_hit_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic void model_lookup(input logic [31:0] la, output logic [3:0] bs, output logic [31:0] d);
    bs = '0;
    d = '0;
    foreach (q[k])
      for (int b = 0; b < 4; b++)
        if (q[k].adr[31:2] == la[31:2] && q[k].bsel[b]) begin
          bs[b] = 1'b1;
          d[8*b +: 8] = q[k].dat[8*b +: 8];
        end
  endfunction
  task automatic compare_all();
    logic [3:0] eb;
    logic [31:0] ed;
    ent_t h;
    h = '{default: '0};
    if (q.size() > 0) h = q[0];
    model_lookup(lookup_adr_i, eb, ed);
    check("count", 64'(count_o), 64'(q.size()));
    check("empty", 64'(empty_o), 64'(q.size() == 0));
    check("full", 64'(full_o), 64'(q.size() == 8));
    check("head_pc", 64'(pc_o), 64'(h.pc));
    check("head_adr", 64'(adr_o), 64'(h.adr));
    check("head_dat", 64'(dat_o), 64'(h.dat));
    check("head_bsel", 64'(bsel_o), 64'(h.bsel));
    check("head_atomic", 64'(atomic_o), 64'(h.atomic));
    check("lk_bsel", 64'(lookup_bsel_o), 64'(eb));
    check("lk_dat", 64'(lookup_dat_o), 64'(ed));
    check("lk_hit", 64'(lookup_hit_o), 64'(eb != 0));
  endtask
  task automatic drive(input logic w, input logic r, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] bs, input logic at, input logic [31:0] la);
    @(negedge clk);
    write_i = w; read_i = r; pc_i = pc; adr_i = a; dat_i = d; bsel_i = bs; atomic_i = at; lookup_adr_i = la;
    #1;
    compare_all();
  endtask
  task automatic commit();
    ent_t n;
    logic mrg, pop, push;
    @(posedge clk);
    n = '{pc: pc_i, adr: adr_i, dat: dat_i, bsel: bsel_i, atomic: atomic_i};
    mrg = COMB && write_i && q.size() > 0 && q[$].adr[31:2] == adr_i[31:2] && !atomic_i &&
          !q[$].atomic && (q.size() > 1 || !read_i);
    pop = read_i && q.size() > 0;
    push = write_i && (q.size() < 8 || read_i) && !mrg;
    if (mrg) begin
      for (int b = 0; b < 4; b++) if (bsel_i[b]) q[$].dat[8*b +: 8] = dat_i[8*b +: 8];
      q[$].bsel = q[$].bsel | bsel_i;
      q[$].pc = pc_i;
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back(n);
  endtask
  task automatic step(input logic w, input logic r, input logic [31:0] pc, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] bs, input logic at, input logic [31:0] la);
    drive(w, r, pc, a, d, bs, at, la);
    commit();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; write_i = 1'b1; read_i = 1'b1; adr_i = 32'h100; bsel_i = 4'hf; lookup_adr_i = 32'h100;
    repeat (2) @(posedge clk);
    q.delete();
    @(negedge clk);
    check("rst_empty", 64'(empty_o), 64'd1);
    check("rst_full", 64'(full_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_pc", 64'(pc_o), 64'd0);
    check("rst_lk_bsel", 64'(lookup_bsel_o), 64'd0);
    check("rst_lk_dat", 64'(lookup_dat_o), 64'd0);
    rst = 1'b0; write_i = 1'b0; read_i = 1'b0;
  endtask
  initial begin
    do_reset();
    for (int k = 0; k < 9; k++) step(1, 0, 32'h40 + k, 32'h1000 + 4*k, 32'hd000 + k, 4'hf, 0, 32'h1000);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h1000);
    check("t1_full", 64'(full_o), 64'd1);
    check("t1_count", 64'(count_o), 64'd8);
    check("t1_head_pc", 64'(pc_o), 64'h40);
    commit();
    step(1, 1, 32'h99, 32'h2000, 32'hbeef, 4'hf, 0, 32'h2000);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h2000);
    check("t2_count", 64'(count_o), 64'd8);
    check("t2_lk_dat", 64'(lookup_dat_o), 64'hbeef);
    commit();
    for (int k = 0; k < 9; k++) step(0, 1, 0, 0, 0, 0, 0, 32'h1004);
    do_reset();
    step(1, 0, 32'h1, 32'h100, 32'h000000aa, 4'b0011, 0, 0);
    step(1, 0, 32'h2, 32'h100, 32'h000000bb, 4'b0001, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h102);
    check("t3_bsel", 64'(lookup_bsel_o), 64'h3);
    check("t3_dat", 64'(lookup_dat_o), 64'hbb);
    commit();
    do_reset();
    for (int k = 0; k < 13; k++) step(1, 1, k, 32'h500, 32'h0 + k, 4'hf, 0, 32'h200);
    step(1, 0, 32'h7, 32'h200, 32'h11111111, 4'hf, 0, 32'h200);
    step(1, 0, 32'h8, 32'h200, 32'h22222222, 4'hf, 0, 32'h200);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h200);
    check("t4_dat", 64'(lookup_dat_o), 64'h22222222);
    commit();
    do_reset();
    step(1, 0, 32'h1, 32'h600, 32'haaaaaaaa, 4'hf, 0, 32'h600);
    drive(1, 1, 32'h2, 32'h600, 32'h55555555, 4'hf, 0, 32'h600);
    check("t5_popped_fwd", 64'(lookup_dat_o), 64'haaaaaaaa);
    commit();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h600);
    check("t5_new_fwd", 64'(lookup_dat_o), 64'h55555555);
    commit();
    do_reset();
    step(1, 0, 32'h10, 32'h300, 32'h000000c1, 4'b0001, 0, 32'h300);
    step(1, 0, 32'h20, 32'h300, 32'h00c20000, 4'b0100, 0, 32'h300);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h300);
    check("t6_count", 64'(count_o), COMB ? 64'd1 : 64'd2);
    check("t6_bsel", 64'(bsel_o), COMB ? 64'h5 : 64'h1);
    check("t6_pc", 64'(pc_o), COMB ? 64'h20 : 64'h10);
    commit();
    step(1, 0, 32'h30, 32'h300, 32'h0000c300, 4'b0010, 1, 32'h300);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h300);
    check("t6_atomic_count", 64'(count_o), COMB ? 64'd2 : 64'd3);
    commit();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int ph, wp;
      ph = (i / 50) % 3;
      wp = ph == 0 ? 80 : ph == 1 ? 50 : 20;
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < 100 - wp, $urandom,
           bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 7) == 0, bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 32'h100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
